seq_pulse_gen: RTL

SEQ_PULSE_GEN -- requirements
Module: seq_pulse_gen

---
 rtl/seq_pulse_pkg.sv | 45 ++++
 rtl/pulse_timer.sv | 30 +++
 rtl/seq_pulse_gen_chk.sv | 27 ++
 rtl/seq_pulse_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_pulse_pkg.sv
// Shared definitions for the three-step pulse sequencer: FSM states,
// per-step line codes and the sequence table.
package seq_pulse_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ZERO = 8'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    IDLE_STEP = 2'd0,
    X1_STEP   = 2'd1,
    X2_STEP   = 2'd2
  } line_t;

  localparam logic [1:0] LAST_STEP = 2'd2;

  // One row per sel value; step 0 sits in the most significant pair.
  localparam logic [5:0] SEQ_TABLE [4] = '{
    {X1_STEP, X2_STEP, X2_STEP},
    {X1_STEP, X1_STEP, X2_STEP},
    {X2_STEP, X1_STEP, X2_STEP},
    {X1_STEP, X2_STEP, X1_STEP}
  };

  function automatic line_t seq_line(input logic [1:0] sel, input logic [1:0] idx);
    logic [5:0] row;
    line_t      res;
    row = SEQ_TABLE[sel];
    case (idx)
      2'd0:    res = line_t'(row[5:4]);
      2'd1:    res = line_t'(row[3:2]);
      2'd2:    res = line_t'(row[1:0]);
      default: res = IDLE_STEP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// 8-bit loadable down counter that saturates at zero; o_tc flags the
// last cycle of the currently timed interval.
module pulse_timer
  import seq_pulse_pkg::*;
(
  input  logic             cp,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: load has priority, otherwise count down and stop at zero.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (r_cnt != CNT_ZERO) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == CNT_ZERO);

endmodule

// File: rtl/seq_pulse_gen_chk.sv
// Protocol properties of the pulse sequencer outputs.
module seq_pulse_gen_chk (
  input logic       cp,
  input logic       rst_n,
  input logic       i_x1,
  input logic       i_x2,
  input logic       i_busy,
  input logic       i_done,
  input logic [1:0] i_step
);

  a_x_exclusive: assert property (@(posedge cp) disable iff (!rst_n)
    !(i_x1 && i_x2));

  a_x_needs_busy: assert property (@(posedge cp) disable iff (!rst_n)
    (i_x1 || i_x2) |-> i_busy);

  a_done_in_busy: assert property (@(posedge cp) disable iff (!rst_n)
    i_done |-> i_busy);

  a_done_single: assert property (@(posedge cp) disable iff (!rst_n)
    i_done |=> !i_done);

  a_idle_step_zero: assert property (@(posedge cp) disable iff (!rst_n)
    !i_busy |-> (i_step == 2'd0));

endmodule

// File: rtl/seq_pulse_gen.sv
// Three-step pulse sequencer: drives PW-cycle pulses on x1/x2 separated by
// GAP idle cycles, following one of four stored sequences.
module seq_pulse_gen
  import seq_pulse_pkg::*;
#(
  parameter int PW  = 4,
  parameter int GAP = 4
) (
  input  logic       cp,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] sel,
  output logic       x1,
  output logic       x2,
  output logic       busy,
  output logic       done,
  output logic [1:0] step,
  output logic       expect_z
);

  // The timer is loaded with length-1 so its terminal count marks the final cycle.
  localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PW - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

  state_t           r_state;
  logic [1:0]       r_step;
  logic [1:0]       r_sel;
  logic             r_x1;
  logic             r_x2;
  logic             r_busy;
  logic             r_done;
  logic             r_expect_z;

  state_t           w_state_nx;
  logic [1:0]       w_step_nx;
  logic [1:0]       w_sel_nx;
  logic             w_done_nx;
  logic             w_expz_nx;
  logic             w_x1_nx;
  logic             w_x2_nx;
  logic             w_busy_nx;
  line_t            w_line_nx;
  logic             w_load;
  logic [CNT_W-1:0] w_len;
  logic             w_tc;

  pulse_timer u_timer (
    .cp     (cp),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_len  (w_len),
    .o_tc   (w_tc)
  );

  // Next-state, timer control and next-output decode.
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_sel_nx   = r_sel;
    w_done_nx  = 1'b0;
    w_expz_nx  = r_expect_z;
    w_load     = 1'b0;
    w_len      = CNT_ZERO;

    if ((r_state != ST_IDLE) && abort) begin
      w_state_nx = ST_IDLE;
      w_step_nx  = 2'd0;
      w_expz_nx  = 1'b0;
      w_load     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_load = 1'b1;
          if (start && !abort) begin
            w_state_nx = ST_PULSE;
            w_step_nx  = 2'd0;
            w_sel_nx   = sel;
            w_len      = PW_LOAD;
            w_expz_nx  = 1'b0;
          end else begin
            w_len = CNT_ZERO;
          end
        end
        ST_PULSE: begin
          if (w_tc) begin
            w_state_nx = ST_GAP;
            w_load     = 1'b1;
            w_len      = GAP_LOAD;
          end else begin
            w_load = 1'b0;
          end
        end
        ST_GAP: begin
          if (w_tc && (r_step < LAST_STEP)) begin
            w_state_nx = ST_PULSE;
            w_step_nx  = r_step + 2'd1;
            w_load     = 1'b1;
            w_len      = PW_LOAD;
          end else if (w_tc) begin
            w_state_nx = ST_FIN;
            w_load     = 1'b1;
            w_done_nx  = 1'b1;
            w_expz_nx  = (r_sel == 2'd0);
          end else begin
            w_load = 1'b0;
          end
        end
        ST_FIN: begin
          w_state_nx = ST_IDLE;
          w_step_nx  = 2'd0;
          w_load     = 1'b1;
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_step_nx  = 2'd0;
          w_expz_nx  = 1'b0;
          w_load     = 1'b1;
        end
      endcase
    end

    w_line_nx = seq_line(w_sel_nx, w_step_nx);
    w_x1_nx   = (w_state_nx == ST_PULSE) && (w_line_nx == X1_STEP);
    w_x2_nx   = (w_state_nx == ST_PULSE) && (w_line_nx == X2_STEP);
    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  // State and output registers; outputs follow the state they belong to.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_step     <= 2'd0;
      r_sel      <= 2'd0;
      r_x1       <= 1'b0;
      r_x2       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_expect_z <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_step     <= w_step_nx;
      r_sel      <= w_sel_nx;
      r_x1       <= w_x1_nx;
      r_x2       <= w_x2_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_expect_z <= w_expz_nx;
    end
  end

  assign x1       = r_x1;
  assign x2       = r_x2;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step     = r_step;
  assign expect_z = r_expect_z;

  seq_pulse_gen_chk u_chk (
    .cp     (cp),
    .rst_n  (rst_n),
    .i_x1   (r_x1),
    .i_x2   (r_x2),
    .i_busy (r_busy),
    .i_done (r_done),
    .i_step (r_step)
  );

endmodule
